// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle ARM-subset control unit: FSM states,
// instruction field values, ALU operations, condition codes and helpers.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_NOP = 2'b11;

  localparam logic [3:0] FUNCT_AND = 4'b0000;
  localparam logic [3:0] FUNCT_SUB = 4'b0010;
  localparam logic [3:0] FUNCT_ADD = 4'b0100;
  localparam logic [3:0] FUNCT_CMP = 4'b1010;
  localparam logic [3:0] FUNCT_ORR = 4'b1100;
  localparam logic [3:0] FUNCT_MOV = 4'b1101;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_ORR = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b011;
  localparam logic [2:0] ALU_MOV = 3'b100;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;

  // flags are packed {N,Z,C,V}
  function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] flags);
    logic n, z, c, v;
    {n, z, c, v} = flags;
    case (cond)
      COND_EQ: cond_eval = z;
      COND_NE: cond_eval = !z;
      COND_CS: cond_eval = c;
      COND_CC: cond_eval = !c;
      COND_MI: cond_eval = n;
      COND_PL: cond_eval = !n;
      COND_VS: cond_eval = v;
      COND_VC: cond_eval = !v;
      COND_HI: cond_eval = c && !z;
      COND_LS: cond_eval = !c || z;
      COND_GE: cond_eval = (n == v);
      COND_LT: cond_eval = (n != v);
      COND_GT: cond_eval = !z && (n == v);
      COND_LE: cond_eval = z || (n != v);
      default: cond_eval = 1'b1;
    endcase
  endfunction

  function automatic logic [2:0] alu_from_funct(input logic [3:0] funct);
    case (funct)
      FUNCT_ADD: alu_from_funct = ALU_ADD;
      FUNCT_SUB: alu_from_funct = ALU_SUB;
      FUNCT_AND: alu_from_funct = ALU_AND;
      FUNCT_ORR: alu_from_funct = ALU_ORR;
      FUNCT_MOV: alu_from_funct = ALU_MOV;
      FUNCT_CMP: alu_from_funct = ALU_SUB;
      default:   alu_from_funct = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/cond_logic.sv
// NZCV flags register and the per-instruction condition-pass bit (CondEx).
// CondEx is captured in DECODE; flags are written at the end of EXECR/EXECI.
module cond_logic
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] i_cond,
  input  logic [3:0] i_alu_flags,
  input  logic       i_cond_ld,
  input  logic       i_flags_ld,
  input  logic [1:0] i_flag_w,
  output logic       o_cond_ex,
  output logic [3:0] o_flags
);

  logic       r_cond_ex;
  logic [3:0] r_flags;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cond_ex <= 1'b0;
      r_flags   <= 4'b0000;
    end else begin
      if (i_cond_ld)
        r_cond_ex <= cond_eval(i_cond, r_flags);
      // A failed condition leaves the flags untouched
      if (i_flags_ld && r_cond_ex) begin
        if (i_flag_w[1]) r_flags[3:2] <= i_alu_flags[3:2];
        if (i_flag_w[0]) r_flags[1:0] <= i_alu_flags[1:0];
      end
    end
  end

  assign o_cond_ex = r_cond_ex;
  assign o_flags   = r_flags;

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM: sequences the shared ALU, memory port and register
// file, driving every datapath select and write enable from state and Instr.
module multicycle_ctrl
  import ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        PCWrite,
  output logic        AdrSrc,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic [1:0]  ResultSrc,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  RegSrc,
  output logic [2:0]  ALUControl
);

  state_t r_state, w_next;

  logic [1:0] w_op;
  logic       w_i, w_s, w_is_cmp, w_cond_ex, w_nz_w, w_cv_ok;
  logic [3:0] w_funct, w_rd, w_cond, w_flags;
  logic       w_pcw, w_memw, w_irw, w_regw;

  assign w_cond   = Instr[31:28];
  assign w_op     = Instr[27:26];
  assign w_i      = Instr[25];
  assign w_funct  = Instr[24:21];
  assign w_s      = Instr[20];
  assign w_rd     = Instr[15:12];
  assign w_is_cmp = (w_funct == FUNCT_CMP);
  assign w_nz_w   = w_s || w_is_cmp;
  assign w_cv_ok  = (w_funct == FUNCT_ADD) || (w_funct == FUNCT_SUB) || w_is_cmp;

  cond_logic u_cond (
    .clk        (clk),
    .reset      (reset),
    .i_cond     (w_cond),
    .i_alu_flags(ALUFlags),
    .i_cond_ld  (r_state == S_DECODE),
    .i_flags_ld ((r_state == S_EXECR) || (r_state == S_EXECI)),
    .i_flag_w   ({w_nz_w, w_nz_w && w_cv_ok}),
    .o_cond_ex  (w_cond_ex),
    .o_flags    (w_flags)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next     = S_FETCH;
    w_pcw      = 1'b0;
    AdrSrc     = 1'b0;
    w_memw     = 1'b0;
    w_irw      = 1'b0;
    w_regw     = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ImmSrc     = 2'b00;
    RegSrc     = 2'b00;
    ALUControl = ALU_ADD;
    case (r_state)
      S_FETCH: begin
        w_irw     = 1'b1;
        w_pcw     = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        w_next    = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        RegSrc    = {w_op == OP_MEM, w_op == OP_BR};
        ImmSrc    = (w_op == OP_NOP) ? 2'b00 : w_op;
        case (w_op)
          OP_MEM:  w_next = S_MEMADR;
          OP_DP:   w_next = w_i ? S_EXECI : S_EXECR;
          OP_BR:   w_next = S_BRANCH;
          default: w_next = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        ALUSrcB = 2'b01;
        ImmSrc  = 2'b01;
        w_next  = w_s ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        AdrSrc = 1'b1;
        w_next = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        w_regw    = w_cond_ex;
      end
      S_MEMWR: begin
        AdrSrc = 1'b1;
        RegSrc = 2'b10;
        w_memw = w_cond_ex;
      end
      S_EXECR, S_EXECI: begin
        ALUSrcB    = (r_state == S_EXECI) ? 2'b01 : 2'b00;
        ALUControl = alu_from_funct(w_funct);
        w_next     = S_ALUWB;
      end
      S_ALUWB: begin
        // Rd=15 turns the writeback into a PC load
        if (!w_is_cmp) begin
          if (w_rd == 4'd15) w_pcw  = w_cond_ex;
          else               w_regw = w_cond_ex;
        end
      end
      S_BRANCH: begin
        RegSrc    = 2'b01;
        ALUSrcB   = 2'b01;
        ImmSrc    = 2'b10;
        ResultSrc = 2'b10;
        w_pcw     = w_cond_ex;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // Architectural writes are blocked in any cycle that reset is high
  assign PCWrite  = w_pcw  && !reset;
  assign MemWrite = w_memw && !reset;
  assign IRWrite  = w_irw  && !reset;
  assign RegWrite = w_regw && !reset;

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multicycle control unit for the ARM-subset processor. It sequences one shared ALU, one unified instruction/data memory port and the register file across several clock cycles per instruction. It owns the NZCV flags register and the condition-check logic. It sits beside the multicycle datapath, reads the latched instruction register and the ALU flags, and drives every mux select and write enable.

## Interface
- No parameters.
- `clk  in  1` — single clock; all state updates on the rising edge.
- `reset  in  1` — synchronous, active-high.
- `Instr  in  32` — instruction register output from the datapath; only valid from DECODE onward.
- `ALUFlags  in  4` — {N,Z,C,V} from the ALU in the current cycle.
- `PCWrite  out  1` — PC load enable.
- `AdrSrc  out  1` — memory address select: 0 = PC, 1 = ALUOut.
- `MemWrite  out  1` — memory write enable.
- `IRWrite  out  1` — instruction register load enable.
- `RegWrite  out  1` — register file write enable.
- `ResultSrc  out  2` — result select: 00 = ALUOut, 01 = read data, 10 = ALU result.
- `ALUSrcA  out  1` — ALU A operand: 0 = RD1, 1 = PC.
- `ALUSrcB  out  2` — ALU B operand: 00 = RD2, 01 = ExtImm, 10 = constant 4.
- `ImmSrc  out  2` — extend select: 00 = 8-bit DP, 01 = 12-bit mem, 10 = 24-bit branch.
- `RegSrc  out  2` — [0] forces RA1 = 15; [1] forces RA2 = Rd.
- `ALUControl  out  3` — 000 AND, 001 ORR, 010 ADD, 011 SUB, 100 MOV.

## Operation
Instruction fields:
- Op = Instr[27:26]; I = Instr[25]; Funct = Instr[24:21]; S/L = Instr[20]; Rd = Instr[15:12]; Cond = Instr[31:28].

FSM states and per-state outputs. Any output not listed is 0, except ALUControl, which defaults to ADD.
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, PCWrite=1. Next state is DECODE.
- DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10 (PC+8 for R15 reads); RegSrc and ImmSrc driven from Op. CondEx is registered here from Cond and the current Flags. Next state by Op:
  - 01 → MEMADR
  - 00 with I=0 → EXECR
  - 00 with I=1 → EXECI
  - 10 → BRANCH
  - 11 → FETCH (NOP)
- MEMADR: ALUSrcA=0, ALUSrcB=01, ImmSrc=01, ADD. Next state is MEMRD if L=1, otherwise MEMWR.
- MEMRD: AdrSrc=1. Next state is MEMWB.
- MEMWB: ResultSrc=01, RegWrite=CondEx. Next state is FETCH.
- MEMWR: AdrSrc=1, RegSrc=10, MemWrite=CondEx. Next state is FETCH.
- EXECR / EXECI: ALUSrcA=0; ALUSrcB=00 (EXECR) or 01 with ImmSrc=00 (EXECI). ALUControl from Funct: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 1101 MOV, 1010 (CMP) SUB; any other Funct gives ADD. Next state is ALUWB.
- ALUWB: ResultSrc=00. Behaviour by instruction:
  - CMP: RegWrite=0.
  - Rd=15: RegWrite=0 and PCWrite=CondEx.
  - Otherwise: RegWrite=CondEx.
  - Next state is FETCH.
- BRANCH: RegSrc=01, ALUSrcA=0, ALUSrcB=01, ImmSrc=10, ADD, ResultSrc=10, PCWrite=CondEx. Next state is FETCH. Instr[24] (BL) is ignored; linking is outside this subset.

Flags:
- Flags register is 4 bits, reset value 0000. It updates only at the end of EXECR/EXECI, and only when CondEx=1.
- NZ is written when S=1 or the instruction is CMP.
- CV is written only for ADD, SUB or CMP under the same condition.

Condition codes:
- 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C; 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V
- 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT !Z&(N==V); 1101 LE Z|(N!=V)
- 1110 and 1111 both evaluate true.

## Timing
- Reset: on a rising edge with reset=1, state←FETCH, Flags←0000, CondEx←0. While reset=1, PCWrite, IRWrite, RegWrite and MemWrite are forced 0.
- The first FETCH is the first cycle after reset deasserts.
- Outputs are combinational from the state and Instr; no output register.
- Cycles per instruction: B 3; DP/CMP 4; STR 4; LDR 5; Op=11 2.
- A failed condition still walks the full state path, with all write enables suppressed; the PC advances normally.
- Flags written in EXECR/EXECI are visible to the CondEx evaluation of the next instruction's DECODE.
- Reset asserted mid-instruction aborts on the next edge. No memory or register write occurs in that cycle.

## Structure
- Package `ctrl_pkg`:
  - state enum (4-bit encoding)
  - Op, Funct, ALUControl and Cond localparams, shared with the decoder and ALU.
- Sub-module `cond_logic`: Flags register, CondEx register, condition evaluation and flag-write gating.
- Main FSM lives in `multicycle_ctrl`.

## Test plan
- Reset held 3 cycles mid-LDR: write enables are 0 throughout; after release, state is FETCH with IRWrite=1, PCWrite=1 and Flags=0000.
- `ADDS R1,R2,R3` (0xE0921003) with ALUFlags=0110 in EXEC: 4 cycles; RegWrite=1 in ALUWB only; Flags become 0110.
- `CMP` then `BEQ` (0x0A000002):
  - with Z=1: PCWrite=1 in BRANCH, with ImmSrc=10;
  - with Z=0: PCWrite=0, 3 cycles total.
- `LDR R0,[R1,#4]` (0xE5910004): states FETCH→DECODE→MEMADR→MEMRD→MEMWB; AdrSrc=1 in MEMRD; ResultSrc=01 with RegWrite=1 in MEMWB.
- `STRNE` with Z=1: MemWrite stays 0; sequence returns to FETCH after 4 cycles.
- `MOV PC,R2` (Rd=15): in ALUWB, RegWrite=0 and PCWrite=1. Op=11 instruction: returns to FETCH after DECODE with no writes.
